// File: rtl/prng_word_gen.sv
// prng_word_gen
//   Fibonacci LFSR that delivers one WIDTH-bit random word per
//   SHIFTS_PER_WORD shifts. Delivery uses a valid/ready handshake. Words are
//   never dropped: if a word completes while the previous one is still
//   pending, the generator parks in HOLD until the consumer accepts.
//
//   Optional build macro: PRNG_ZERO_GUARD_EN. When it is defined, an all-zero
//   state (loaded or reached) is replaced by SEED and zero_fix pulses.
//
// Ports
//   clock      in   rising-edge clock for all logic
//   reset      in   synchronous active-high reset
//   enable     in   1 = LFSR advances, 0 = freeze
//   seed_load  in   one-cycle strobe that loads seed_in
//   seed_in    in   [WIDTH] seed value
//   rnd        out  [WIDTH] registered random word
//   rnd_valid  out  rnd holds an unconsumed word
//   rnd_ready  in   consumer accepts rnd while rnd_valid is high
//   stall      out  generator parked in HOLD
//   zero_fix   out  one-cycle pulse when a zero state was replaced by SEED
module prng_word_gen #(
  parameter int unsigned      WIDTH           = 13,
  parameter logic [WIDTH-1:0] TAPS            = 13'h100D,
  parameter int unsigned      SHIFTS_PER_WORD = 13,
  parameter logic [WIDTH-1:0] SEED            = 13'h000F
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] rnd,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             stall,
  output logic             zero_fix
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } fsm_t;

  localparam logic [7:0] LAST_CNT = 8'(SHIFTS_PER_WORD - 1);

  // Feedback parity over the tapped state bits.
  function automatic logic fb_parity(input logic [WIDTH-1:0] s);
    return ^(s & TAPS);
  endfunction

  // One Fibonacci shift: the feedback bit enters at bit 0.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], fb_parity(s)};
  endfunction

  fsm_t             fsm_r;
  fsm_t             fsm_s;
  logic [WIDTH-1:0] lfsr_r;
  logic [7:0]       cnt_r;
  logic [WIDTH-1:0] rnd_r;
  logic             rnd_valid_r;
  logic             stall_r;
  logic             stall_s;
  logic             zero_fix_r;

  logic             advance_s;
  logic             word_done_s;
  logic             blocked_s;
  logic             hold_release_s;
  logic [WIDTH-1:0] candidate_s;
  logic [WIDTH-1:0] fixed_s;
  logic             zero_hit_s;

  // Shift and handshake qualifiers for the current cycle.
  always_comb begin
    advance_s      = enable && (fsm_r != ST_HOLD);
    word_done_s    = advance_s && (cnt_r == LAST_CNT);
    // A finished word that cannot be presented yet parks the generator.
    blocked_s      = word_done_s && rnd_valid_r && !rnd_ready;
    hold_release_s = (fsm_r == ST_HOLD) && rnd_ready;
    if (seed_load) begin
      candidate_s = seed_in;
    end else begin
      candidate_s = lfsr_next(lfsr_r);
    end
  end

`ifdef PRNG_ZERO_GUARD_EN
  // Substitute SEED for any all-zero value that is about to be loaded.
  always_comb begin
    zero_hit_s = (seed_load || advance_s) && (candidate_s == {WIDTH{1'b0}});
    if (zero_hit_s) begin
      fixed_s = SEED;
    end else begin
      fixed_s = candidate_s;
    end
  end
`else
  // Without the guard, values pass through unchanged and a zero state locks up.
  always_comb begin
    zero_hit_s = 1'b0;
    fixed_s    = candidate_s;
  end
`endif

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_r <= ST_IDLE;
    end else begin
      fsm_r <= fsm_s;
    end
  end

  // FSM next-state logic; a seed load restarts the word from any state.
  always_comb begin
    fsm_s = fsm_r;
    if (seed_load) begin
      fsm_s = enable ? ST_RUN : ST_IDLE;
    end else begin
      case (fsm_r)
        ST_IDLE, ST_RUN: begin
          if (blocked_s) begin
            fsm_s = ST_HOLD;
          end else if (enable) begin
            fsm_s = ST_RUN;
          end else begin
            fsm_s = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (rnd_ready) begin
            fsm_s = enable ? ST_RUN : ST_IDLE;
          end else begin
            fsm_s = ST_HOLD;
          end
        end
        default: fsm_s = ST_IDLE;
      endcase
    end
  end

  // FSM output decode, registered below so that stall tracks the FSM register.
  always_comb begin
    stall_s = (fsm_s == ST_HOLD);
  end

  // LFSR state and shift counter. In HOLD both stay parked on the completed word.
  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr_r <= SEED;
      cnt_r  <= 8'd0;
    end else if (seed_load) begin
      lfsr_r <= fixed_s;
      cnt_r  <= 8'd0;
    end else if (advance_s) begin
      lfsr_r <= fixed_s;
      cnt_r  <= word_done_s ? 8'd0 : (cnt_r + 8'd1);
    end
  end

  // Word delivery, handshake and status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      rnd_r       <= {WIDTH{1'b0}};
      rnd_valid_r <= 1'b0;
      stall_r     <= 1'b0;
      zero_fix_r  <= 1'b0;
    end else begin
      stall_r    <= stall_s;
      zero_fix_r <= zero_hit_s;
      if (seed_load) begin
        rnd_valid_r <= 1'b0;
      end else if (word_done_s && !blocked_s) begin
        rnd_r       <= fixed_s;
        rnd_valid_r <= 1'b1;
      end else if (hold_release_s) begin
        // The parked word replaces the one being accepted on this edge.
        rnd_r       <= lfsr_r;
        rnd_valid_r <= 1'b1;
      end else if (rnd_valid_r && rnd_ready) begin
        rnd_valid_r <= 1'b0;
      end
    end
  end

  assign rnd       = rnd_r;
  assign rnd_valid = rnd_valid_r;
  assign stall     = stall_r;
  assign zero_fix  = zero_fix_r;

endmodule

// File: tb/tb_prng_word_gen.sv
module tb_prng_word_gen;

  localparam logic [12:0] TAPS_M = 13'h100D;
  localparam logic [12:0] SEED_M = 13'h000F;

  logic        clock;
  logic        reset;
  logic        enable;
  logic        seed_load;
  logic [12:0] seed_in;
  logic [12:0] rnd;
  logic        rnd_valid;
  logic        rnd_ready;
  logic        stall;
  logic        zero_fix;

  int          n_checks;
  int          n_errors;
  int          consumed;
  logic [12:0] exp_q[$];

  prng_word_gen dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .seed_load (seed_load),
    .seed_in   (seed_in),
    .rnd       (rnd),
    .rnd_valid (rnd_valid),
    .rnd_ready (rnd_ready),
    .stall     (stall),
    .zero_fix  (zero_fix)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference LFSR step, bit-serial over the tap mask.
  function automatic logic [12:0] model_step(input logic [12:0] s);
    logic [12:0] t;
    logic        fb;
    t  = TAPS_M;
    fb = 1'b0;
    for (int i = 0; i < 13; i++) begin
      if (t[i]) fb = fb ^ s[i];
    end
    return {s[11:0], fb};
  endfunction

  function automatic logic [12:0] model_word(input logic [12:0] s);
    logic [12:0] v;
    v = s;
    for (int k = 0; k < 13; k++) v = model_step(v);
    return v;
  endfunction

  // Refill the scoreboard with the words expected after a (re)seed.
  task automatic sb_load(input logic [12:0] seed);
    logic [12:0] s;
    exp_q.delete();
    consumed = 0;
    s = seed;
    for (int k = 0; k < 8; k++) begin
      s = model_word(s);
      exp_q.push_back(s);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enable    = 1'b0;
    seed_load = 1'b0;
    exp_q.delete();
    tick(1);
    reset = 1'b0;
  endtask

  // Scoreboard monitor: every accepted word must be the next expected one.
  always @(negedge clock) begin
    if (!reset && !seed_load && rnd_valid && rnd_ready) begin
      if (exp_q.size() == 0) begin
        check_val("sb_underflow", 64'(exp_q.size()), 64'd1);
      end else begin
        check_val("sb_word", 64'(rnd), 64'(exp_q.pop_front()));
        consumed++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] w2;
    n_checks  = 0;
    n_errors  = 0;
    consumed  = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    seed_load = 1'b0;
    seed_in   = 13'h0000;
    rnd_ready = 1'b1;
    tick(2);
    check_val("rst_rnd",      64'(rnd),       64'h0);
    check_val("rst_valid",    64'(rnd_valid), 64'h0);
    check_val("rst_stall",    64'(stall),     64'h0);
    check_val("rst_zero_fix", 64'(zero_fix),  64'h0);
    reset = 1'b0;

    // First word latency and value, free-running consumer.
    sb_load(SEED_M);
    enable = 1'b1;
    tick(12);
    check_val("w1_not_yet", 64'(rnd_valid), 64'h0);
    tick(1);
    check_val("w1_valid", 64'(rnd_valid), 64'h1);
    check_val("w1_value", 64'(rnd), 64'h1FF4);
    tick(1);
    check_val("w1_taken", 64'(rnd_valid), 64'h0);
    tick(30);
    check_val("run_count", 64'(consumed), 64'd3);

    // Back-pressure: HOLD, no word skipped.
    do_reset();
    rnd_ready = 1'b0;
    sb_load(SEED_M);
    w2 = model_word(model_word(SEED_M));
    enable = 1'b1;
    tick(13);
    check_val("bp_w1", 64'(rnd), 64'h1FF4);
    tick(12);
    check_val("bp_stall_pre", 64'(stall), 64'h0);
    tick(1);
    check_val("bp_stall", 64'(stall), 64'h1);
    tick(14);
    check_val("bp_stall_held", 64'(stall), 64'h1);
    check_val("bp_w1_held", 64'(rnd), 64'h1FF4);
    check_val("bp_none_taken", 64'(consumed), 64'd0);
    rnd_ready = 1'b1;
    tick(1);
    check_val("bp_w2", 64'(rnd), 64'(w2));
    check_val("bp_w2_valid", 64'(rnd_valid), 64'h1);
    check_val("bp_unstall", 64'(stall), 64'h0);
    tick(1);
    check_val("bp_w2_taken", 64'(rnd_valid), 64'h0);
    tick(28);
    check_val("bp_count", 64'(consumed), 64'd4);

    // Seed load mid-word restarts the word.
    do_reset();
    rnd_ready = 1'b1;
    sb_load(SEED_M);
    enable = 1'b1;
    tick(13);
    tick(7);
    seed_load = 1'b1;
    seed_in   = 13'h000F;
    sb_load(13'h000F);
    tick(1);
    seed_load = 1'b0;
    check_val("sl_valid", 64'(rnd_valid), 64'h0);
    check_val("sl_rnd_kept", 64'(rnd), 64'h1FF4);
    tick(12);
    check_val("sl_not_yet", 64'(rnd_valid), 64'h0);
    tick(1);
    check_val("sl_valid2", 64'(rnd_valid), 64'h1);
    check_val("sl_value", 64'(rnd), 64'h1FF4);

    // Enable low for 5 cycles after shift 6 delays the word by 5 cycles.
    do_reset();
    rnd_ready = 1'b1;
    sb_load(SEED_M);
    enable = 1'b1;
    tick(6);
    enable = 1'b0;
    tick(5);
    check_val("en_frozen", 64'(rnd_valid), 64'h0);
    enable = 1'b1;
    tick(6);
    check_val("en_not_yet", 64'(rnd_valid), 64'h0);
    tick(1);
    check_val("en_valid", 64'(rnd_valid), 64'h1);
    check_val("en_value", 64'(rnd), 64'h1FF4);

    // Reset while parked in HOLD discards everything.
    do_reset();
    rnd_ready = 1'b0;
    enable    = 1'b1;
    tick(26);
    check_val("hr_stall", 64'(stall), 64'h1);
    reset = 1'b1;
    exp_q.delete();
    tick(1);
    reset = 1'b0;
    check_val("hr_rnd", 64'(rnd), 64'h0);
    check_val("hr_valid", 64'(rnd_valid), 64'h0);
    check_val("hr_stall_clr", 64'(stall), 64'h0);
    rnd_ready = 1'b1;
    sb_load(SEED_M);
    tick(13);
    check_val("hr_seed_word", 64'(rnd), 64'h1FF4);

    // All-zero seed.
    do_reset();
    rnd_ready = 1'b1;
    enable    = 1'b1;
    seed_load = 1'b1;
    seed_in   = 13'h0000;
`ifdef PRNG_ZERO_GUARD_EN
    sb_load(SEED_M);
    tick(1);
    seed_load = 1'b0;
    check_val("zg_pulse", 64'(zero_fix), 64'h1);
    tick(1);
    check_val("zg_pulse_end", 64'(zero_fix), 64'h0);
    tick(12);
    check_val("zg_word", 64'(rnd), 64'h1FF4);
`else
    sb_load(13'h0000);
    tick(1);
    seed_load = 1'b0;
    check_val("zn_no_pulse", 64'(zero_fix), 64'h0);
    tick(13);
    check_val("zn_valid", 64'(rnd_valid), 64'h1);
    check_val("zn_word", 64'(rnd), 64'h0);
`endif
    tick(20);
    check_val("zero_count", 64'(consumed), 64'd2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/prng_word_gen.md
PRNG_WORD_GEN -- requirements
Module: prng_word_gen

Interface
REQ-001 Parameter WIDTH, default 13, LFSR and output word width in bits (3..64).
REQ-002 Parameter TAPS, default 13'h100D, WIDTH-bit feedback tap mask; bit i set means state[i] enters feedback.
REQ-003 Parameter SHIFTS_PER_WORD, default 13, LFSR shifts per delivered word (1..255).
REQ-004 Parameter SEED, default 13'h000F, WIDTH-bit reset/recovery state, nonzero.
REQ-005 clock  input  1  single clock, all logic rising-edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 enable  input  1  high = LFSR advances; low = freeze.
REQ-008 seed_load  input  1  one-cycle strobe, loads seed_in.
REQ-009 seed_in  input  WIDTH  seed value sampled when seed_load high.
REQ-010 rnd  output  WIDTH  registered random word.
REQ-011 rnd_valid  output  1  rnd holds an unconsumed word.
REQ-012 rnd_ready  input  1  consumer accepts rnd when rnd_valid high.
REQ-013 stall  output  1  high while FSM in HOLD.
REQ-014 zero_fix  output  1  one-cycle pulse when all-zero state was replaced by SEED (guard build only; else tied 0).

Function
REQ-015 Fibonacci LFSR: fb = XOR-reduce(state & TAPS); next = {state[WIDTH-2:0], fb}; one shift per cycle in RUN.
REQ-016 Shift counter counts 0..SHIFTS_PER_WORD-1, wraps to 0 on the shift completing a word.
REQ-017 On the edge performing the word-completing shift, rnd <= next state and rnd_valid <= 1 (latency SHIFTS_PER_WORD cycles from RUN entry).
REQ-018 Transfer occurs on any edge with rnd_valid && rnd_ready; rnd_valid clears next cycle unless a new word completes on that same edge, then rnd updates and rnd_valid stays 1.
REQ-019 FSM states IDLE, RUN, HOLD; IDLE->RUN when enable=1; RUN->IDLE when enable=0; RUN->HOLD when word completes while rnd_valid=1 and rnd_ready=0 (new word not captured, LFSR and counter freeze on completing state).
REQ-020 In HOLD, the pending completed word is captured on the edge rnd_ready=1 is seen, then FSM -> RUN (enable=1) or IDLE (enable=0); no word is ever dropped or overwritten.
REQ-021 enable=0 mid-word freezes state and counter; pending rnd/rnd_valid and handshake remain active; enable=1 resumes from frozen point.
REQ-022 seed_load has priority over enable and handshake: state <= seed_in, counter <= 0, rnd_valid <= 0, rnd unchanged, FSM -> RUN if enable else IDLE.
REQ-023 stall = (FSM == HOLD), registered.

Reset
REQ-024 On reset=1 at an edge: state <= SEED, counter <= 0, rnd <= 0, rnd_valid <= 0, stall <= 0, zero_fix <= 0, FSM <= IDLE; reset overrides seed_load.
REQ-025 Reset mid-word or in HOLD discards the partial word and any pending rnd.

Configuration
REQ-026 Macro PRNG_ZERO_GUARD_EN defined: seed_in of all zeros, or any state reaching all zeros, is replaced by SEED on that edge and zero_fix pulses for one cycle.
REQ-027 PRNG_ZERO_GUARD_EN undefined: seed_in loaded verbatim; all-zero state locks up producing zero words; zero_fix constant 0; no detection logic.

Verification
REQ-028 Defaults, reset then enable=1, rnd_ready=1 -> after 4 shifts state 0x00FF; on 13th shift edge rnd=0x1FF4, rnd_valid=1.
REQ-029 rnd_ready=0 held 40 cycles -> first word 0x1FF4 held, stall=1 from 26th shift on, LFSR frozen; raise rnd_ready -> 0x1FF4 consumed, next word delivered, none skipped.
REQ-030 seed_load=1, seed_in=0x000F at shift 7 of a word -> counter 0, rnd_valid=0, next word again 0x1FF4 after 13 cycles.
REQ-031 enable=0 for 5 cycles after shift 6 -> state and counter unchanged; word completes 5 cycles later than undisturbed run, value 0x1FF4.
REQ-032 Guard build, seed_load with seed_in=0 -> state=0x000F, zero_fix one-cycle pulse; non-guard build -> state stays 0, words 0x0000.
REQ-033 reset asserted while in HOLD with rnd_valid=1 -> next cycle rnd=0, rnd_valid=0, stall=0, state=0x000F.
